// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller:
// hex segment table, blank pattern and FSM state encodings.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low abcdefg; entry n is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h38, 7'h30, 7'h42, 7'h31,
    7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C,
    7'h06, 7'h12, 7'h4F, 7'h01
  };

  typedef enum logic [1:0] {
    DARK = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display data in / segment drive out bundle for seg7_scan_ctrl.
// master = data source and display side, slave = the controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    pix_clk;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              cathode;
  logic                    dp_out;
  logic                    frame_start;

  modport master (
    output pix_clk, data_in, dp_in, blank_in,
    input  anode, cathode, dp_out, frame_start
  );

  modport slave (
    input  pix_clk, data_in, dp_in, blank_in,
    output anode, cathode, dp_out, frame_start
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low abcdefg segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with dark gaps.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int GHOST_CYC  = 2
) (
  input logic             clk_in,
  input logic             reset,
  seg7_scan_ctrl_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GW = (GHOST_CYC > 0) ? $clog2(GHOST_CYC + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic s1, s2, s3, tick;

  state_t state, nxt_state;
  logic [IW-1:0] idx, nxt_idx;
  logic [GW-1:0] gap_cnt, nxt_gap;
  logic [4*NUM_DIGITS-1:0] snap_data, nxt_data;
  logic [NUM_DIGITS-1:0] snap_dp, nxt_dp;
  logic [NUM_DIGITS-1:0] snap_blank, nxt_blank;
  logic [NUM_DIGITS-1:0] anode_q, nxt_anode;
  logic [6:0] cath_q, nxt_cath;
  logic dp_q, nxt_dpo;
  logic fs_q, nxt_fs;

  logic [NUM_DIGITS-1:0] lz;
  logic [3:0] sel_nib;
  logic sel_dp, sel_blank;
  logic [6:0] seg;

  assign tick = s2 & ~s3;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.pix_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic seen;
  // Digits above the highest non-zero nibble go dark; digit 0 never does.
  always_comb begin
    lz = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (nxt_data[4*k +: 4] != 4'h0) seen = 1'b1;
      lz[k] = ~seen;
    end
  end
`else
  assign lz = '0;
`endif

  // Decode works on the post-tick index and snapshot.
  always_comb begin
    sel_nib = 4'h0;
    sel_dp = 1'b0;
    sel_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (nxt_idx == IW'(k)) begin
        sel_nib = nxt_data[4*k +: 4];
        sel_dp = nxt_dp[k];
        sel_blank = nxt_blank[k] | lz[k];
      end
    end
  end

  hex_to_seg7 u_dec (
    .nib (sel_nib),
    .seg (seg)
  );

  always_comb begin
    nxt_state = state;
    nxt_idx = idx;
    nxt_gap = gap_cnt;
    nxt_data = snap_data;
    nxt_dp = snap_dp;
    nxt_blank = snap_blank;
    nxt_anode = anode_q;
    nxt_cath = cath_q;
    nxt_dpo = dp_q;
    nxt_fs = 1'b0;
    if (tick) begin
      if (state == DARK || idx == LAST) begin
        nxt_idx = '0;
        nxt_data = bus.data_in;
        nxt_dp = bus.dp_in;
        nxt_blank = bus.blank_in;
      end else begin
        nxt_idx = idx + 1'b1;
      end
      nxt_anode = '1;
      nxt_cath = sel_blank ? SEG_BLANK : seg;
      nxt_dpo = sel_blank | ~sel_dp;
      if (GHOST_CYC == 0) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          nxt_anode[k] = (nxt_idx != IW'(k));
        nxt_fs = (nxt_idx == '0);
        nxt_state = SHOW;
      end else begin
        nxt_gap = GW'(GHOST_CYC);
        nxt_state = GAP;
      end
    end else if (state == GAP) begin
      if (gap_cnt <= GW'(1)) begin
        for (int k = 0; k < NUM_DIGITS; k++)
          nxt_anode[k] = (idx != IW'(k));
        nxt_fs = (idx == '0);
        nxt_state = SHOW;
      end else begin
        nxt_gap = gap_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= DARK;
      idx <= '0;
      gap_cnt <= '0;
      snap_data <= '0;
      snap_dp <= '0;
      snap_blank <= '0;
      anode_q <= '1;
      cath_q <= SEG_BLANK;
      dp_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      state <= nxt_state;
      idx <= nxt_idx;
      gap_cnt <= nxt_gap;
      snap_data <= nxt_data;
      snap_dp <= nxt_dp;
      snap_blank <= nxt_blank;
      anode_q <= nxt_anode;
      cath_q <= nxt_cath;
      dp_q <= nxt_dpo;
      fs_q <= nxt_fs;
    end
  end

  assign bus.anode = anode_q;
  assign bus.cathode = cath_q;
  assign bus.dp_out = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (8 digits, 2-cycle gap).
// Leading-zero checks follow SEG7_LEADING_ZERO_BLANK_EN when defined.
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  logic [6:0] hexc [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  seg7_scan_ctrl_if #(.NUM_DIGITS(8)) bus ();

  seg7_scan_ctrl #(.NUM_DIGITS(8), .GHOST_CYC(2)) dut (
    .clk_in (clk),
    .reset  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // One pix_clk pulse; reports what the controller shows for that digit.
  task automatic step_digit(
    output logic       gap_ok,
    output logic [7:0] an_on,
    output logic [6:0] cath,
    output logic       dpo,
    output logic       fs_on,
    output logic       fs_off
  );
    bus.pix_clk = 1'b1;
    repeat (3) @(negedge clk);
    gap_ok = (bus.anode == 8'hFF) && !bus.frame_start;
    cath = bus.cathode;
    dpo = bus.dp_out;
    @(negedge clk);
    gap_ok = gap_ok && (bus.anode == 8'hFF) && !bus.frame_start;
    @(negedge clk);
    an_on = bus.anode;
    fs_on = bus.frame_start;
    @(negedge clk);
    fs_off = bus.frame_start;
    if (bus.anode != an_on) fs_off = 1'bx;
    bus.pix_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    bus.pix_clk = 1'b0;
    bus.data_in = 32'h7654_3210;
    bus.dp_in = 8'h00;
    bus.blank_in = 8'h00;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.anode !== 8'hFF || bus.cathode !== 7'h7F ||
        bus.dp_out !== 1'b1 || bus.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got an=%h ca=%h dp=%b fs=%b exp FF 7F 1 0",
               bus.anode, bus.cathode, bus.dp_out, bus.frame_start);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.anode !== 8'hFF || bus.cathode !== 7'h7F ||
          bus.frame_start !== 1'b0) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL startup_idle cyc %0d got an=%h ca=%h fs=%b exp FF 7F 0",
                   i, bus.anode, bus.cathode, bus.frame_start);
        bad++;
      end
    end
  endtask

  task automatic test_basic_scan();
    logic g, d, f1, f0;
    logic [7:0] a;
    logic [6:0] c;
    for (int k = 0; k < 8; k++) begin
      step_digit(g, a, c, d, f1, f0);
      n_chk++;
      if (g !== 1'b1 || a !== ~(8'h01 << k) || c !== hexc[k] ||
          d !== 1'b1 || f1 !== (k == 0) || f0 !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_scan d%0d got gap=%b an=%h ca=%h dp=%b fs=%b/%b exp 1 %h %h 1 %b/0",
                 k, g, a, c, d, f1, f0, ~(8'h01 << k), hexc[k], k == 0);
      end
    end
  endtask

  task automatic test_tearing();
    logic g, d, f1, f0;
    logic [7:0] a;
    logic [6:0] c;
    for (int n = 0; n < 16; n++) begin
      if (n == 3) bus.data_in = 32'hFFFF_FFFF;
      step_digit(g, a, c, d, f1, f0);
      n_chk++;
      if (a !== ~(8'h01 << (n % 8)) ||
          c !== ((n < 8) ? hexc[n] : 7'h38)) begin
        n_fail++;
        $display("FAIL tearing step%0d got an=%h ca=%h exp %h %h",
                 n, a, c, ~(8'h01 << (n % 8)), (n < 8) ? hexc[n] : 7'h38);
      end
    end
  endtask

  task automatic test_blank_dp();
    logic g, d, f1, f0;
    logic [7:0] a;
    logic [6:0] c;
    logic [6:0] ec;
    bus.data_in = 32'h7654_3210;
    bus.blank_in = 8'h02;
    bus.dp_in = 8'h04;
    for (int k = 0; k < 8; k++) begin
      step_digit(g, a, c, d, f1, f0);
      ec = (k == 1) ? 7'h7F : hexc[k];
      n_chk++;
      if (a !== ~(8'h01 << k) || c !== ec || d !== (k != 2)) begin
        n_fail++;
        $display("FAIL blank_dp d%0d got an=%h ca=%h dp=%b exp %h %h %b",
                 k, a, c, d, ~(8'h01 << k), ec, k != 2);
      end
    end
    bus.blank_in = 8'h00;
    bus.dp_in = 8'h00;
  endtask

  task automatic test_reset_mid_gap();
    logic g, d, f1, f0;
    logic [7:0] a;
    logic [6:0] c;
    int bad;
    bus.pix_clk = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (bus.anode !== 8'hFF || bus.cathode !== 7'h01) begin
      n_fail++;
      $display("FAIL pre_reset_gap got an=%h ca=%h exp FF 01",
               bus.anode, bus.cathode);
    end
    rst = 1'b1;
    bus.pix_clk = 1'b0;
    #1;
    n_chk++;
    if (bus.anode !== 8'hFF || bus.cathode !== 7'h7F ||
        bus.dp_out !== 1'b1 || bus.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got an=%h ca=%h dp=%b fs=%b exp FF 7F 1 0",
               bus.anode, bus.cathode, bus.dp_out, bus.frame_start);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.data_in = 32'h89AB_CDEF;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.anode !== 8'hFF || bus.cathode !== 7'h7F) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle got %0d lit cycles exp 0", bad);
    end
    step_digit(g, a, c, d, f1, f0);
    n_chk++;
    if (a !== 8'hFE || c !== 7'h38 || f1 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_d0 got an=%h ca=%h fs=%b exp FE 38 1", a, c, f1);
    end
  endtask

  task automatic test_leading_zero();
    logic g, d, f1, f0;
    logic [7:0] a;
    logic [6:0] c;
    logic [6:0] ec;
    rst = 1'b1;
    bus.pix_clk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.data_in = 32'h0000_0050;
    @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      step_digit(g, a, c, d, f1, f0);
      if (n == 0) bus.data_in = 32'h0000_0000;
      if (n < 8)
        ec = (n == 1) ? 7'h24 : 7'h01;
      else
        ec = 7'h01;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (n < 8 && n >= 2) ec = 7'h7F;
      if (n >= 9) ec = 7'h7F;
`endif
      n_chk++;
      if (a !== ~(8'h01 << (n % 8)) || c !== ec || d !== 1'b1) begin
        n_fail++;
        $display("FAIL leading_zero step%0d got an=%h ca=%h dp=%b exp %h %h 1",
                 n, a, c, d, ~(8'h01 << (n % 8)), ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tearing();
    test_blank_dp();
    test_reset_mid_gap();
    test_leading_zero();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Consumes the 480 Hz `pix_clk` square wave from the display clock divider and time-multiplexes up to eight hex digits onto the board's common-anode 7-segment displays.
- Runs entirely on the board clock. `pix_clk` is treated as an asynchronous level, synchronised and edge-detected into a one-cycle scan tick.
- Snapshots the display data once per frame (no tearing) and inserts an anti-ghosting dark gap between digits.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..8).
- GHOST_CYC, 2, `clk_in` cycles with all anodes off after each digit change (0 = no gap).

Ports:
- clk_in  input  1  board clock.
- reset  input  1  asynchronous, active-high reset.
- pix_clk  input  1  scan clock from divider; asynchronous to `clk_in`.
- data_in  input  4*NUM_DIGITS  hex nibbles; digit k = data_in[4k+3:4k]; digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
- blank_in  input  NUM_DIGITS  force digit dark, active-high.
- anode  output  NUM_DIGITS  active-low digit enables.
- cathode  output  7  active-low segments; [6]=a … [0]=g.
- dp_out  output  1  active-low decimal point.
- frame_start  output  1  one-cycle pulse when digit 0 is enabled.

Behaviour:
- Reset (async, immediate):
  - anode all 1, cathode 7'h7F, dp_out 1, frame_start 0.
  - Sync flops, digit index, gap counter and snapshot registers all 0.
  - FSM enters DARK.
- Tick generation:
  - `pix_clk` passes through sync flops s1→s2, then s3 holds the previous s2; tick = s2 & ~s3.
  - Exactly one tick per `pix_clk` rising edge. Falling edges are ignored.
  - The first tick fires on the 3rd `clk_in` edge after `pix_clk` rises (setup met).
- FSM states: DARK, GAP, SHOW.
- DARK:
  - All outputs stay at reset values until the first tick.
  - On the first tick: idx←0, snapshot←{data_in, dp_in, blank_in}, then go to GAP (or straight to SHOW if GHOST_CYC=0).
- On every tick in GAP or SHOW:
  - idx←(idx==NUM_DIGITS-1) ? 0 : idx+1.
  - The snapshot reloads only when idx wraps to 0. Inputs are otherwise ignored mid-frame.
  - anode←all 1; cathode and dp_out are updated to the new digit on the same edge; gap counter←GHOST_CYC; go to GAP.
- GAP:
  - Counter decrements each cycle.
  - When it reaches 1 (or immediately if GHOST_CYC=0): anode[idx]←0, all other anode bits 1; go to SHOW.
  - frame_start=1 for that one cycle if idx==0.
- SHOW: hold outputs until the next tick.
- Tick arriving while in GAP: restart the gap for the next digit; the previous digit is never enabled.
- Segment decode (active-low abcdefg), registered:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Digit with blank=1: cathode 7'h7F, dp_out 1. Its anode is still enabled, which keeps scan timing uniform.
- dp_out = ~dp for the current digit, registered alongside cathode.
- Frame period: NUM_DIGITS ticks. NUM_DIGITS=1 means idx stays 0 and the snapshot reloads every tick.
- Reset asserted mid-scan: outputs go dark immediately; the scan restarts in DARK.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Within the snapshot, every digit above the highest non-zero nibble is treated as blanked.
  - Digit 0 is never auto-blanked.
  - dp of an auto-blanked digit is also suppressed.
  - blank_in still ORs in.
- Undefined: only blank_in blanks a digit; zero nibbles display "0".

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry hex segment table constants;
  - SEG_BLANK = 7'h7F;
  - FSM state encodings (DARK=2'd0, GAP=2'd1, SHOW=2'd2).
- Sub-module hex_to_seg7: combinational 4-bit → 7-bit decoder, instantiated once on the selected nibble.

Test Plan:
- Startup: deassert reset and hold `pix_clk` low for 1000 cycles → anode 8'hFF, cathode 7'h7F, frame_start 0 throughout.
- Basic scan: data_in=32'h7654_3210, GHOST_CYC=2, eight `pix_clk` rising edges →
  - anode sequence FE,FD,FB,…,7F, each preceded by 2 cycles of FF;
  - cathode shows 0..7 codes in order;
  - one frame_start pulse, at the FE enable.
- Tearing: change data_in to 32'hFFFF_FFFF after the 3rd tick → digits 3..7 of this frame still show 3..7; next frame shows F on all digits.
- Blank and dp: blank_in=8'h02, dp_in=8'h04 → digit 1 gives cathode 7F with anode FD still enabled; digit 2 gives dp_out 0.
- Reset mid-GAP: assert reset 1 cycle after a tick → outputs dark on the same cycle; after release, nothing happens until the next tick, which shows digit 0 with a fresh snapshot.
- With SEG7_LEADING_ZERO_BLANK_EN, data_in=32'h0000_0050 → digits 7..2 dark, digit 1 = "5", digit 0 = "0". With data_in=0, only digit 0 shows "0".
